// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// These cover the FSM state encoding and the BCD digit limits.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    // Time is packed as {min_dez, min_uni, seg_dez, seg_uni}.
    function automatic logic is_zero_time(input logic [15:0] t);
        return t == 16'h0000;
    endfunction

    function automatic logic is_one_second(input logic [15:0] t);
        return t == 16'h0001;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with a parameterised wrap value.
// It produces a borrow when it wraps, so several instances can be chained.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [3:0] WRAP = BCD_NINE
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic [3:0] o_digit,
    output logic       o_borrow
);

    logic [3:0] r_digit;

    always_ff @(posedge clk) begin
        if (i_reset || i_load) begin
            r_digit <= i_load_val;
        end else if (i_en) begin
            r_digit <= (r_digit == BCD_ZERO) ? WRAP : r_digit - 4'd1;
        end
    end

    assign o_digit  = r_digit;
    assign o_borrow = i_en && (r_digit == BCD_ZERO);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: the 1 Hz prescaler and run/pause/expire FSM drive
// a chain of four BCD down-counting digits.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter logic [7:0]  INIT_MIN = 8'h02,
    parameter logic [7:0]  INIT_SEC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    output logic [3:0] min_dez,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] seg_uni,
    output logic       running,
    output logic       expired,
    output logic       tick
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ - 1);
    localparam logic PRESET_ZERO = is_zero_time({INIT_MIN, INIT_SEC});

    state_e        r_state;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_expired;
    logic          r_tick;

    logic [15:0]   w_digits;
    logic          w_terminal;
    logic          w_dec;
    logic          w_to_zero;
    logic          w_b_su;
    logic          w_b_sd;
    logic          w_b_mu;
    logic          w_b_md;

    assign w_digits   = {min_dez, min_uni, seg_dez, seg_uni};
    assign w_terminal = (r_presc == P_LAST);

    // A decrement is applied only at the terminal count, never when overridden
    // by restart/pause, and never at 00:00.
    assign w_dec = (r_state == ST_RUNNING) && !restart && !pause && w_terminal
                   && !is_zero_time(w_digits);
    assign w_to_zero = w_dec && is_one_second(w_digits);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (restart) begin
                r_state   <= ST_IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start && !pause) begin
                            r_presc <= '0;
                            if (PRESET_ZERO) begin
                                r_state   <= ST_EXPIRED;
                                r_expired <= 1'b1;
                            end else begin
                                r_state   <= ST_RUNNING;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    ST_RUNNING: begin
                        if (pause) begin
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end else if (w_terminal) begin
                            r_presc <= '0;
                            r_tick  <= w_dec;
                            if (w_to_zero || is_zero_time(w_digits)) begin
                                r_state   <= ST_EXPIRED;
                                r_running <= 1'b0;
                                r_expired <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    ST_PAUSED: begin
                        // Prescaler is held so the partial second survives.
                        if (start && !pause) begin
                            r_state   <= ST_RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        r_state <= ST_EXPIRED;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    bcd_down_digit #(
        .WRAP(BCD_NINE)
    ) u_seg_uni (
        .clk       (clk),
        .i_reset   (reset),
        .i_load    (restart),
        .i_load_val(INIT_SEC[3:0]),
        .i_en      (w_dec),
        .o_digit   (seg_uni),
        .o_borrow  (w_b_su)
    );

    bcd_down_digit #(
        .WRAP(BCD_FIVE)
    ) u_seg_dez (
        .clk       (clk),
        .i_reset   (reset),
        .i_load    (restart),
        .i_load_val(INIT_SEC[7:4]),
        .i_en      (w_b_su),
        .o_digit   (seg_dez),
        .o_borrow  (w_b_sd)
    );

    bcd_down_digit #(
        .WRAP(BCD_NINE)
    ) u_min_uni (
        .clk       (clk),
        .i_reset   (reset),
        .i_load    (restart),
        .i_load_val(INIT_MIN[3:0]),
        .i_en      (w_b_sd),
        .o_digit   (min_uni),
        .o_borrow  (w_b_mu)
    );

    bcd_down_digit #(
        .WRAP(BCD_NINE)
    ) u_min_dez (
        .clk       (clk),
        .i_reset   (reset),
        .i_load    (restart),
        .i_load_val(INIT_MIN[7:4]),
        .i_en      (w_b_mu),
        .o_digit   (min_dez),
        .o_borrow  (w_b_md)
    );

    assign running = r_running;
    assign expired = r_expired;
    assign tick    = r_tick;

    logic w_unused;
    assign w_unused = w_b_md;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: three instances with presets 02:00,
// 00:02 and 00:00 share clock and reset but have separate controls.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, pause_a = 1'b0, restart_a = 1'b0;
    logic start_b = 1'b0, pause_b = 1'b0, restart_b = 1'b0;
    logic start_c = 1'b0, pause_c = 1'b0, restart_c = 1'b0;

    logic [3:0] md_a, mu_a, sd_a, su_a, md_b, mu_b, sd_b, su_b, md_c, mu_c, sd_c, su_c;
    logic run_a, exp_a, tick_a, run_b, exp_b, tick_b, run_c, exp_c, tick_c;
    logic [15:0] dig_a, dig_b, dig_c;

    int total = 0;
    int bad = 0;

    assign dig_a = {md_a, mu_a, sd_a, su_a};
    assign dig_b = {md_b, mu_b, sd_b, su_b};
    assign dig_c = {md_c, mu_c, sd_c, su_c};

    always #5 clk = ~clk;

    countdown_timer #(.CLK_FREQ(4), .INIT_MIN(8'h02), .INIT_SEC(8'h00)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pause(pause_a), .restart(restart_a),
        .min_dez(md_a), .min_uni(mu_a), .seg_dez(sd_a), .seg_uni(su_a),
        .running(run_a), .expired(exp_a), .tick(tick_a)
    );

    countdown_timer #(.CLK_FREQ(4), .INIT_MIN(8'h00), .INIT_SEC(8'h02)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pause(pause_b), .restart(restart_b),
        .min_dez(md_b), .min_uni(mu_b), .seg_dez(sd_b), .seg_uni(su_b),
        .running(run_b), .expired(exp_b), .tick(tick_b)
    );

    countdown_timer #(.CLK_FREQ(4), .INIT_MIN(8'h00), .INIT_SEC(8'h00)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .pause(pause_c), .restart(restart_c),
        .min_dez(md_c), .min_uni(mu_c), .seg_dez(sd_c), .seg_uni(su_c),
        .running(run_c), .expired(exp_c), .tick(tick_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        // 1: reset and idle hold
        step();
        step();
        reset = 1'b0;
        chk("rst_digits", dig_a, 16'h0200);
        chk("rst_running", {15'd0, run_a}, 16'd0);
        chk("rst_expired", {15'd0, exp_a}, 16'd0);
        chk("rst_tick", {15'd0, tick_a}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_tick", {15'd0, tick_a}, 16'd0);
        end
        chk("idle_digits", dig_a, 16'h0200);

        // 2: run two seconds
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("run_running", {15'd0, run_a}, 16'd1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("run_tick", {15'd0, tick_a}, (i % 4 == 0) ? 16'd1 : 16'd0);
            chk("run_digits", dig_a, (i < 4) ? 16'h0200 : (i < 8) ? 16'h0159 : 16'h0158);
        end

        // 3: pause after two prescaler cycles, resume keeps partial second
        step();
        step();
        pause_a = 1'b1;
        step();
        pause_a = 1'b0;
        chk("pause_running", {15'd0, run_a}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_tick", {15'd0, tick_a}, 16'd0);
            chk("pause_digits", dig_a, 16'h0158);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("resume_running", {15'd0, run_a}, 16'd1);
        step();
        chk("resume_tick1", {15'd0, tick_a}, 16'd0);
        step();
        chk("resume_tick2", {15'd0, tick_a}, 16'd1);
        chk("resume_digits", dig_a, 16'h0157);

        // 5: restart beats start, pause beats start, pause beats terminal count
        restart_a = 1'b1;
        start_a = 1'b1;
        step();
        restart_a = 1'b0;
        start_a = 1'b0;
        chk("rs_digits", dig_a, 16'h0200);
        chk("rs_running", {15'd0, run_a}, 16'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        pause_a = 1'b1;
        start_a = 1'b1;
        step();
        pause_a = 1'b0;
        start_a = 1'b0;
        chk("ps_running", {15'd0, run_a}, 16'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        pause_a = 1'b1;
        step();
        pause_a = 1'b0;
        chk("pterm_running", {15'd0, run_a}, 16'd0);
        chk("pterm_tick", {15'd0, tick_a}, 16'd0);
        chk("pterm_digits", dig_a, 16'h0200);

        // 6: reset mid-count at 01:37
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (dig_a != 16'h0137 && n < 200) begin
            step();
            n++;
        end
        chk("reach_0137", dig_a, 16'h0137);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_digits", dig_a, 16'h0200);
        chk("mid_rst_running", {15'd0, run_a}, 16'd0);
        chk("mid_rst_tick", {15'd0, tick_a}, 16'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("post_rst_tick", {15'd0, tick_a}, (i == 4) ? 16'd1 : 16'd0);
        end
        chk("post_rst_digits", dig_a, 16'h0159);

        // 4: preset 00:02 runs to expiry
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("b_digits", dig_b, (i < 4) ? 16'h0002 : (i < 8) ? 16'h0001 : 16'h0000);
            chk("b_expired", {15'd0, exp_b}, (i == 8) ? 16'd1 : 16'd0);
            chk("b_running", {15'd0, run_b}, (i == 8) ? 16'd0 : 16'd1);
        end
        chk("b_last_tick", {15'd0, tick_b}, 16'd1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        pause_b = 1'b1;
        step();
        pause_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("b_hold_digits", dig_b, 16'h0000);
            chk("b_hold_expired", {15'd0, exp_b}, 16'd1);
            chk("b_hold_tick", {15'd0, tick_b}, 16'd0);
        end
        restart_b = 1'b1;
        step();
        restart_b = 1'b0;
        chk("b_restart_digits", dig_b, 16'h0002);
        chk("b_restart_expired", {15'd0, exp_b}, 16'd0);
        chk("b_restart_running", {15'd0, run_b}, 16'd0);

        // 6b: preset 00:00 start goes straight to expired
        chk("c_idle_expired", {15'd0, exp_c}, 16'd0);
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        chk("c_expired", {15'd0, exp_c}, 16'd1);
        chk("c_running", {15'd0, run_c}, 16'd0);
        chk("c_digits", dig_c, 16'h0000);
        chk("c_tick", {15'd0, tick_c}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
